// File: rtl/timer_display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_display_pkg                                                    |
// | Shared 7-segment codes, anode patterns and converter state encoding. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package timer_display_pkg;

   // Segment codes {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] AN_SEC_ONES = 4'b1110;
   localparam logic [3:0] AN_SEC_TENS = 4'b1101;
   localparam logic [3:0] AN_MIN_ONES = 4'b1011;
   localparam logic [3:0] AN_MIN_TENS = 4'b0111;
   localparam logic [3:0] AN_OFF      = 4'b1111;

   typedef enum logic [1:0] {
      CONV_IDLE    = 2'd0,
      CONV_CAPTURE = 2'd1,
      CONV_DIV     = 2'd2,
      CONV_COMMIT  = 2'd3
   } conv_state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] i_digit);
      logic [6:0] w_code;
      case (i_digit)
         4'd0:    w_code = SEG_0;
         4'd1:    w_code = SEG_1;
         4'd2:    w_code = SEG_2;
         4'd3:    w_code = SEG_3;
         4'd4:    w_code = SEG_4;
         4'd5:    w_code = SEG_5;
         4'd6:    w_code = SEG_6;
         4'd7:    w_code = SEG_7;
         4'd8:    w_code = SEG_8;
         4'd9:    w_code = SEG_9;
         default: w_code = SEG_BLANK;
      endcase
      return w_code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/timer_display_bin2bcd_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2bcd_iter                                                         |
// | Iterative repeated-subtract converter for the MM and SS pair.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bin2bcd_iter
   import timer_display_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   output logic [3:0] o_min_tens,
   output logic [3:0] o_min_ones,
   output logic [3:0] o_sec_tens,
   output logic [3:0] o_sec_ones
);

   conv_state_t r_state;
   logic [5:0]  r_cap_min;
   logic [5:0]  r_cap_sec;
   logic [5:0]  r_wmin;
   logic [5:0]  r_wsec;
   logic [2:0]  r_tmin;
   logic [2:0]  r_tsec;

   logic        w_min_ge10;
   logic        w_sec_ge10;
   logic [5:0]  w_wmin_nxt;
   logic [5:0]  w_wsec_nxt;

   always_comb begin
      w_min_ge10 = (r_wmin >= 6'd10);
      w_sec_ge10 = (r_wsec >= 6'd10);
      w_wmin_nxt = w_min_ge10 ? (r_wmin - 6'd10) : r_wmin;
      w_wsec_nxt = w_sec_ge10 ? (r_wsec - 6'd10) : r_wsec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= CONV_IDLE;
         r_cap_min  <= '0;
         r_cap_sec  <= '0;
         r_wmin     <= '0;
         r_wsec     <= '0;
         r_tmin     <= '0;
         r_tsec     <= '0;
         o_min_tens <= '0;
         o_min_ones <= '0;
         o_sec_tens <= '0;
         o_sec_ones <= '0;
      end else begin
         case (r_state)
            CONV_IDLE: begin
               if ({min, sec} != {r_cap_min, r_cap_sec})
                  r_state <= CONV_CAPTURE;
            end
            CONV_CAPTURE: begin
               r_cap_min <= min;
               r_cap_sec <= sec;
               r_wmin    <= min;
               r_wsec    <= sec;
               r_tmin    <= '0;
               r_tsec    <= '0;
               r_state   <= CONV_DIV;
            end
            CONV_DIV: begin
               r_wmin <= w_wmin_nxt;
               r_wsec <= w_wsec_nxt;
               if (w_min_ge10) r_tmin <= r_tmin + 3'd1;
               if (w_sec_ge10) r_tsec <= r_tsec + 3'd1;
               // Leave as soon as the remainders that will be stored are final
               if ((w_wmin_nxt < 6'd10) && (w_wsec_nxt < 6'd10))
                  r_state <= CONV_COMMIT;
            end
            CONV_COMMIT: begin
               o_min_tens <= {1'b0, r_tmin};
               o_min_ones <= r_wmin[3:0];
               o_sec_tens <= {1'b0, r_tsec};
               o_sec_ones <= r_wsec[3:0];
               r_state    <= CONV_IDLE;
            end
            default: r_state <= CONV_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/timer_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_display                                                        |
// | MM:SS multiplexed 7-segment driver with time-up blink and alarm.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module timer_display
   import timer_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 25000000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic       timeUp,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       alarm
);

   localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [REF_W-1:0]   C_REF_LAST   = REF_W'(REFRESH_DIV - 1);
   localparam logic [BLINK_W-1:0] C_BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [3:0]         w_min_tens;
   logic [3:0]         w_min_ones;
   logic [3:0]         w_sec_tens;
   logic [3:0]         w_sec_ones;
   logic [3:0]         w_digit;
   logic [3:0]         w_an;
   logic               w_blank;

   logic [REF_W-1:0]   r_ref_cnt;
   logic [1:0]         r_idx;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic               r_phase_on;
   logic [6:0]         r_seg;
   logic               r_dp;
   logic [3:0]         r_an;
   logic               r_alarm;

   bin2bcd_iter u_conv (
      .clk        (clk),
      .rst        (rst),
      .min        (min),
      .sec        (sec),
      .o_min_tens (w_min_tens),
      .o_min_ones (w_min_ones),
      .o_sec_tens (w_sec_tens),
      .o_sec_ones (w_sec_ones)
   );

   always_comb begin
      w_digit = w_sec_ones;
      w_an    = AN_SEC_ONES;
      case (r_idx)
         2'd0: begin w_digit = w_sec_ones; w_an = AN_SEC_ONES; end
         2'd1: begin w_digit = w_sec_tens; w_an = AN_SEC_TENS; end
         2'd2: begin w_digit = w_min_ones; w_an = AN_MIN_ONES; end
         2'd3: begin w_digit = w_min_tens; w_an = AN_MIN_TENS; end
         default: begin w_digit = w_sec_ones; w_an = AN_SEC_ONES; end
      endcase
      w_blank = timeUp && !r_phase_on;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ref_cnt   <= '0;
         r_idx       <= '0;
         r_blink_cnt <= '0;
         r_phase_on  <= 1'b1;
         r_seg       <= SEG_BLANK;
         r_dp        <= 1'b1;
         r_an        <= AN_OFF;
         r_alarm     <= 1'b0;
      end else begin
         if (r_ref_cnt == C_REF_LAST) begin
            r_ref_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
         end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
         end

         // Dropping timeUp wins over a wrap on the same edge, so the next blink starts ON
         if (!timeUp) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
         end else if (r_blink_cnt == C_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase_on  <= !r_phase_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end

         // Anode, segment and dp all derive from the same r_idx, so they switch together
         r_seg   <= seg_decode(w_digit);
         r_an    <= w_blank ? AN_OFF : w_an;
         r_dp    <= !((r_idx == 2'd2) && !w_blank);
         r_alarm <= timeUp && r_phase_on;
      end
   end

   assign seg   = r_seg;
   assign dp    = r_dp;
   assign an    = r_an;
   assign alarm = r_alarm;

endmodule
`default_nettype wire
